// File: rtl/tone_frequency_meter.sv
// Tone frequency meter: counts hysteretic rising midscale crossings of an 8-bit
// sample stream over a fixed gate window and reports the scaled count in Hz.
module tone_frequency_meter #(
    parameter int unsigned GATE_SAMPLES  = 4000,
    parameter int unsigned SCALE_SHIFT   = 3,
    parameter int unsigned HIGH_THRESH   = 160,
    parameter int unsigned LOW_THRESH    = 96,
    parameter int unsigned MIN_CROSSINGS = 2
) (
    input  logic        CLK_32KHz,
    input  logic        reset,
    input  logic [7:0]  inputSample,
    input  logic        sampleValid,
    output logic [13:0] measuredFrequency,
    output logic        frequencyValid,
    output logic        signalPresent,
    output logic        crossingPulse
);

    localparam int unsigned CW = $clog2(GATE_SAMPLES + 1);
    localparam int unsigned TW = CW + 1;
    localparam int unsigned SW = 14 + SCALE_SHIFT;

    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_SAMPLES - 1);
    localparam logic [TW-1:0] MIN_X     = TW'(MIN_CROSSINGS);
    localparam logic [SW-1:0] FREQ_MAX  = SW'(16383);
    localparam logic [7:0]    HI        = 8'(HIGH_THRESH);
    localparam logic [7:0]    LO        = 8'(LOW_THRESH);

    typedef enum logic [1:0] {
        ACQUIRE,
        LOW,
        HIGH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  gate_q, gate_d;
    logic [CW-1:0]  cross_q, cross_d;
    logic [13:0]    freq_q, freq_d;
    logic           fvalid_q, fvalid_d;
    logic           present_q, present_d;
    logic           xpulse_q, xpulse_d;

    logic           crossing;
    logic [TW-1:0]  total;
    logic [SW-1:0]  scaled;

    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            state_q   <= ACQUIRE;
            gate_q    <= '0;
            cross_q   <= '0;
            freq_q    <= '0;
            fvalid_q  <= 1'b0;
            present_q <= 1'b0;
            xpulse_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            cross_q   <= cross_d;
            freq_q    <= freq_d;
            fvalid_q  <= fvalid_d;
            present_q <= present_d;
            xpulse_q  <= xpulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        cross_d   = cross_q;
        freq_d    = freq_q;
        fvalid_d  = 1'b0;
        present_d = present_q;
        xpulse_d  = 1'b0;
        crossing  = 1'b0;
        total     = '0;
        scaled    = '0;

        if (sampleValid) begin
            case (state_q)
                LOW: begin
                    if (inputSample >= HI) begin
                        state_d  = HIGH;
                        crossing = 1'b1;
                    end
                end
                HIGH: begin
                    if (inputSample <= LO) state_d = LOW;
                end
                default: begin
                    // Entry into HIGH from ACQUIRE has no known prior LOW, so it is not a crossing
                    if (inputSample >= HI)      state_d = HIGH;
                    else if (inputSample <= LO) state_d = LOW;
                end
            endcase

            xpulse_d = crossing;

            if (gate_q == GATE_LAST) begin
                total     = TW'(cross_q) + TW'(crossing);
                scaled    = SW'(total) << SCALE_SHIFT;
                freq_d    = (scaled > FREQ_MAX) ? 14'h3FFF : scaled[13:0];
                present_d = (total >= MIN_X);
                fvalid_d  = 1'b1;
                cross_d   = '0;
                gate_d    = '0;
            end else begin
                gate_d = gate_q + CW'(1);
                if (crossing && (cross_q != '1)) cross_d = cross_q + CW'(1);
            end
        end
    end

    assign measuredFrequency = freq_q;
    assign frequencyValid    = fvalid_q;
    assign signalPresent     = present_q;
    assign crossingPulse     = xpulse_q;

endmodule

// File: tb/tb_tone_frequency_meter.sv
// Self-checking bench for tone_frequency_meter: randomized tones and patterns
// compared every cycle against a window-level behavioural model.
module tb_tone_frequency_meter;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  smp = 8'd128;
    logic        vld = 1'b0;

    logic [13:0] freq_a, freq_b;
    logic        fv_a, fv_b, pr_a, pr_b, xp_a, xp_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    tone_frequency_meter u_dut (
        .CLK_32KHz        (clk),
        .reset            (rst),
        .inputSample      (smp),
        .sampleValid      (vld),
        .measuredFrequency(freq_a),
        .frequencyValid   (fv_a),
        .signalPresent    (pr_a),
        .crossingPulse    (xp_a)
    );

    tone_frequency_meter #(.SCALE_SHIFT(4)) u_dut4 (
        .CLK_32KHz        (clk),
        .reset            (rst),
        .inputSample      (smp),
        .sampleValid      (vld),
        .measuredFrequency(freq_b),
        .frequencyValid   (fv_b),
        .signalPresent    (pr_b),
        .crossingPulse    (xp_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: remember which side of the band the signal was last seen on;
    // a rise to HIGH after being seen LOW is one crossing.
    int region = 0;            // 0 unknown, 1 last seen low, 2 last seen high
    int nsamp  = 0;
    int ncross = 0;
    int e_freq = 0, e_freq4 = 0;
    bit e_fv = 0, e_pr = 0, e_xp = 0;

    always @(posedge clk) begin
        int tot;
        bit crossed;
        e_fv = 0;
        e_xp = 0;
        if (rst) begin
            region = 0; nsamp = 0; ncross = 0;
            e_freq = 0; e_freq4 = 0; e_pr = 0;
        end else if (vld) begin
            crossed = (smp >= 160) && (region == 1);
            if (smp >= 160)     region = 2;
            else if (smp <= 96) region = 1;
            e_xp = crossed;
            tot = ncross + int'(crossed);
            if (nsamp == 3999) begin
                e_freq  = (tot * 8  > 16383) ? 16383 : tot * 8;
                e_freq4 = (tot * 16 > 16383) ? 16383 : tot * 16;
                e_pr    = (tot >= 2);
                e_fv    = 1;
                nsamp   = 0;
                ncross  = 0;
            end else begin
                nsamp++;
                ncross = tot;
            end
        end
    end

    int fv_count = 0, xp_count = 0;
    int last_freq = -1, last_freq4 = -1;
    bit last_pr = 0;

    always @(negedge clk) begin
        check("freq",     16'(freq_a), 16'(e_freq));
        check("fvalid",   16'(fv_a),   16'(e_fv));
        check("present",  16'(pr_a),   16'(e_pr));
        check("xpulse",   16'(xp_a),   16'(e_xp));
        check("freq_s4",  16'(freq_b), 16'(e_freq4));
        check("fvalid_s4",16'(fv_b),   16'(e_fv));
        check("present_s4",16'(pr_b),  16'(e_pr));
        check("xpulse_s4",16'(xp_b),   16'(e_xp));
        if (fv_a) begin
            fv_count++;
            last_freq  = int'(freq_a);
            last_freq4 = int'(freq_b);
            last_pr    = pr_a;
        end
        if (xp_a) xp_count++;
    end

    task automatic drive(input logic [7:0] s, input logic v);
        smp = s;
        vld = v;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #2;
        if (chk) begin
            check("rst_freq",    16'(freq_a), 16'd0);
            check("rst_fvalid",  16'(fv_a),   16'd0);
            check("rst_present", 16'(pr_a),   16'd0);
            check("rst_xpulse",  16'(xp_a),   16'd0);
        end
        rst = 1'b0;
    endtask

    function automatic logic [7:0] sine_at(input real f, input real amp, input real ph, input int n);
        real v;
        v = 128.0 + amp * $sin(2.0 * PI * f * real'(n) / 32000.0 + ph);
        if (v < 0.0)   v = 0.0;
        if (v > 255.0) v = 255.0;
        return 8'($rtoi(v + 0.5));
    endfunction

    task automatic run_tone(input real f, input int windows, input int pct);
        real amp, ph;
        int n;
        bit v;
        amp = 100.0 + real'($urandom_range(0, 27));
        ph  = real'($urandom_range(0, 628)) / 100.0;
        n = 0;
        while (n < windows * 4000) begin
            v = ($urandom_range(0, 99) < pct);
            drive(sine_at(f, amp, ph, n), v);
            if (v) n++;
        end
        drive(8'd128, 1'b0);
        drive(8'd128, 1'b0);
    endtask

    // kind: 0 constant midscale, 1 square 0,0,255,255, 2 alternating 0/255,
    //       3 hysteresis toggle 100/150 after one low, 4 uniform random
    task automatic run_pattern(input int kind, input int nvalid, input int pct);
        int n;
        bit v;
        logic [7:0] s;
        n = 0;
        while (n < nvalid) begin
            v = ($urandom_range(0, 99) < pct);
            case (kind)
                0:       s = 8'd128;
                1:       s = ((n % 4) < 2) ? 8'd0 : 8'd255;
                2:       s = (n % 2 == 1) ? 8'd255 : 8'd0;
                3:       s = (n == 0) ? 8'd0 : ((n % 2 == 1) ? 8'd150 : 8'd100);
                default: s = 8'($urandom_range(0, 255));
            endcase
            drive(s, v);
            if (v) n++;
        end
        drive(8'd128, 1'b0);
        drive(8'd128, 1'b0);
    endtask

    initial begin
        int base_fv, base_xp, k;
        #2;
        do_reset(1'b1);

        // 1000 Hz tone, continuous samples
        base_fv = fv_count;
        run_tone(1000.0, 3, 100);
        check("f1000_pulses",  16'(fv_count - base_fv), 16'd3);
        check("f1000_freq",    16'(last_freq), 16'd1000);
        check("f1000_present", 16'(last_pr),   16'd1);

        // 440 Hz tone with random sampleValid gaps
        do_reset(1'b0);
        base_fv = fv_count;
        run_tone(440.0, 3, 85);
        check("f440_pulses", 16'(fv_count - base_fv), 16'd3);
        check("f440_freq",   16'(last_freq), 16'd440);

        // constant midscale
        do_reset(1'b0);
        base_fv = fv_count;
        run_pattern(0, 8000, 100);
        check("const_pulses",  16'(fv_count - base_fv), 16'd2);
        check("const_freq",    16'(last_freq), 16'd0);
        check("const_present", 16'(last_pr),   16'd0);

        // 8 kHz square
        do_reset(1'b0);
        run_pattern(1, 8000, 100);
        check("sq_freq",    16'(last_freq),  16'd8000);
        check("sq_freq_s4", 16'(last_freq4), 16'd16000);

        // alternating per sample: saturates the shift-4 instance
        do_reset(1'b0);
        run_pattern(2, 8000, 100);
        check("alt_freq",    16'(last_freq),  16'd16000);
        check("alt_freq_s4", 16'(last_freq4), 16'd16383);

        // toggling inside the hysteresis band
        do_reset(1'b0);
        base_xp = xp_count;
        run_pattern(3, 4000, 80);
        check("hyst_xpulses", 16'(xp_count - base_xp), 16'd0);
        check("hyst_freq",    16'(last_freq), 16'd0);

        // random samples with random gaps, model-checked only
        do_reset(1'b0);
        run_pattern(4, 6000, 75);

        // reset mid-window, then a window with a 50-cycle sampleValid hole
        do_reset(1'b0);
        run_pattern(1, 2000, 100);
        do_reset(1'b1);
        base_fv = fv_count;
        k = 0;
        for (int i = 0; i < 4050; i++) begin
            if (i >= 2000 && i < 2050) begin
                drive(8'd128, 1'b0);
            end else begin
                drive(((k % 4) < 2) ? 8'd0 : 8'd255, 1'b1);
                k++;
            end
            if (i < 4049) check("gap_no_early_pulse", 16'(fv_a), 16'd0);
        end
        check("gap_pulse_on_time", 16'(fv_a),   16'd1);
        check("gap_freq",          16'(freq_a), 16'd8000);
        drive(8'd128, 1'b0);
        drive(8'd128, 1'b0);
        check("gap_pulse_count", 16'(fv_count - base_fv), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
